// File: rtl/divider_if.sv
// Start/ready handshake and operand/result bundle for the multi-cycle signed divider.
// DIVIDER_REMAINDER_EN adds the div_remainder result signal.
interface divider_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ctrl_DIV;
  logic [DATA_WIDTH-1:0] data_operandA;
  logic [DATA_WIDTH-1:0] data_operandB;
  logic [DATA_WIDTH-1:0] div_result;
  logic                  div_exception;
  logic                  div_ready;
`ifdef DIVIDER_REMAINDER_EN
  logic [DATA_WIDTH-1:0] div_remainder;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  div_result, div_exception, div_ready, div_remainder
  );
  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output div_result, div_exception, div_ready, div_remainder
  );
`else
  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  div_result, div_exception, div_ready
  );
  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output div_result, div_exception, div_ready
  );
`endif
endinterface

// File: rtl/divider.sv
// Multi-cycle signed divider: radix-2 restoring divide on magnitudes, one bit per cycle, then a sign-fix cycle.
// Define DIVIDER_REMAINDER_EN to also produce a signed remainder (sign follows the dividend).
module divider #(
  parameter int DATA_WIDTH = 32
) (
  input logic      clk,
  input logic      stop_DIV,
  divider_if.slave bus
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      count_reg;
  logic [DATA_WIDTH-1:0] rem_reg;
  logic [DATA_WIDTH-1:0] quo_reg;
  logic [DATA_WIDTH-1:0] divisor_reg;
  logic                  sign_q_reg;
  logic                  div0_reg;
  logic                  ovf_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic                  exc_reg;
  logic                  ready_reg;
`ifdef DIVIDER_REMAINDER_EN
  logic                  sign_r_reg;
  logic [DATA_WIDTH-1:0] remainder_reg;
`endif

  logic [DATA_WIDTH-1:0] a_abs, b_abs;
  logic [DATA_WIDTH:0]   rem_shift, rem_trial;
  logic                  last_iter;

  assign a_abs = bus.data_operandA[DATA_WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign b_abs = bus.data_operandB[DATA_WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  // The restored remainder is always below |B|, so only the shifted value needs the extra bit.
  assign rem_shift = {rem_reg, quo_reg[DATA_WIDTH-1]};
  assign rem_trial = rem_shift - {1'b0, divisor_reg};
  assign last_iter = (count_reg == CNT_W'(DATA_WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    if (bus.ctrl_DIV) begin
      state_next = BUSY;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        BUSY:    state_next = last_iter ? FIX : BUSY;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (stop_DIV) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (stop_DIV) begin
      count_reg     <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      divisor_reg   <= '0;
      sign_q_reg    <= 1'b0;
      div0_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      result_reg    <= '0;
      exc_reg       <= 1'b0;
      ready_reg     <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
      sign_r_reg    <= 1'b0;
      remainder_reg <= '0;
`endif
    end else begin
      ready_reg <= 1'b0;
      if (bus.ctrl_DIV) begin
        // A start in any state discards the running operation.
        count_reg   <= '0;
        rem_reg     <= '0;
        quo_reg     <= a_abs;
        divisor_reg <= b_abs;
        sign_q_reg  <= bus.data_operandA[DATA_WIDTH-1] ^ bus.data_operandB[DATA_WIDTH-1];
        div0_reg    <= (bus.data_operandB == '0);
        ovf_reg     <= (bus.data_operandA == MIN_NEG) && (bus.data_operandB == '1);
`ifdef DIVIDER_REMAINDER_EN
        sign_r_reg  <= bus.data_operandA[DATA_WIDTH-1];
`endif
      end else begin
        case (state_reg)
          BUSY: begin
            count_reg <= count_reg + 1'b1;
            if (!rem_trial[DATA_WIDTH]) begin
              rem_reg <= rem_trial[DATA_WIDTH-1:0];
              quo_reg <= {quo_reg[DATA_WIDTH-2:0], 1'b1};
            end else begin
              rem_reg <= rem_shift[DATA_WIDTH-1:0];
              quo_reg <= {quo_reg[DATA_WIDTH-2:0], 1'b0};
            end
          end
          FIX: begin
            ready_reg <= 1'b1;
            exc_reg   <= div0_reg | ovf_reg;
            if (div0_reg) begin
              result_reg <= '0;
            end else if (ovf_reg) begin
              result_reg <= MIN_NEG;
            end else begin
              result_reg <= sign_q_reg ? -quo_reg : quo_reg;
            end
`ifdef DIVIDER_REMAINDER_EN
            if (div0_reg || ovf_reg) begin
              remainder_reg <= '0;
            end else begin
              remainder_reg <= sign_r_reg ? -rem_reg : rem_reg;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.div_result    = result_reg;
  assign bus.div_ready     = ready_reg;
  assign bus.div_exception = exc_reg & ready_reg;
`ifdef DIVIDER_REMAINDER_EN
  assign bus.div_remainder = remainder_reg;
`endif
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases plus randomized operands against an arithmetic model.
// Remainder checks are compiled in when DIVIDER_REMAINDER_EN is defined.
module tb_divider;
  localparam int DW      = 32;
  localparam int LATENCY = 33;
  localparam int LIMIT   = 40;

  logic clk = 1'b0;
  logic stop_DIV;
  int   compared = 0;
  int   mismatched = 0;

  divider_if #(.DATA_WIDTH(DW)) bus ();
  divider #(.DATA_WIDTH(DW)) dut (.clk(clk), .stop_DIV(stop_DIV), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed division truncating toward zero, with the divide-by-zero and overflow rules.
  function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                output logic [DW-1:0] q, output logic [DW-1:0] r,
                                output logic e);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = '0; r = '0; e = 1'b1;
    end else if (sa == -64'sd2147483648 && sb == -1) begin
      q = 32'h8000_0000; r = '0; e = 1'b1;
    end else begin
      q = DW'(sa / sb); r = DW'(sa % sb); e = 1'b0;
    end
  endfunction

  task automatic start(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    tick();
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
  endtask

  // Counts edges after the start edge until div_ready is seen, giving up at LIMIT.
  task automatic wait_ready(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (bus.div_ready !== 1'b1 && edges < LIMIT);
  endtask

  task automatic run_op(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] q, r;
    logic e;
    int edges;
    model(a, b, q, r, e);
    start(a, b);
    wait_ready(edges);
    compared++;
    if (edges !== LATENCY) begin
      mismatched++;
      $display("FAIL %s latency: got %0d edges, need %0d (A=%h B=%h)", name, edges, LATENCY, a, b);
    end
    compared++;
    if (bus.div_result !== q || bus.div_exception !== e) begin
      mismatched++;
      $display("FAIL %s result: got %h exc=%b, need %h exc=%b (A=%h B=%h)",
               name, bus.div_result, bus.div_exception, q, e, a, b);
    end
`ifdef DIVIDER_REMAINDER_EN
    compared++;
    if (bus.div_remainder !== r) begin
      mismatched++;
      $display("FAIL %s remainder: got %h, need %h (A=%h B=%h)", name, bus.div_remainder, r, a, b);
    end
`endif
    tick();
    compared++;
    if (bus.div_ready !== 1'b0 || bus.div_exception !== 1'b0 || bus.div_result !== q) begin
      mismatched++;
      $display("FAIL %s after_ready: got ready=%b exc=%b res=%h, need ready=0 exc=0 res=%h",
               name, bus.div_ready, bus.div_exception, bus.div_result, q);
    end
    $display("op %-10s A=%h B=%h -> Q=%h R=%h exc=%b", name, a, b, q, r, e);
  endtask

  task automatic test_reset();
    stop_DIV = 1'b1;
    bus.ctrl_DIV = 1'b1;
    bus.data_operandA = 32'd100;
    bus.data_operandB = 32'd7;
    repeat (3) tick();
    compared++;
    if (bus.div_ready !== 1'b0 || bus.div_exception !== 1'b0 || bus.div_result !== '0) begin
      mismatched++;
      $display("FAIL reset: got ready=%b exc=%b res=%h, need all 0",
               bus.div_ready, bus.div_exception, bus.div_result);
    end
    bus.ctrl_DIV = 1'b0;
    stop_DIV = 1'b0;
    tick();
    $display("reset done");
  endtask

  task automatic test_signs();
    run_op("basic", 32'd100, 32'd7);
    run_op("neg_a", 32'hFFFF_FF9C, 32'd7);
    run_op("neg_b", 32'd100, 32'hFFFF_FFF9);
    run_op("neg_ab", 32'hFFFF_FF9C, 32'hFFFF_FFF9);
  endtask

  task automatic test_exceptions();
    run_op("div0", 32'd5, 32'd0);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("minneg_1", 32'h8000_0000, 32'd1);
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b, q, r;
    logic e;
    int edges;
    for (int i = 0; i < 12; i++) begin
      a = $urandom();
      b = (i % 3 == 0) ? DW'($urandom_range(1, 300)) : $urandom();
      if (i % 4 == 1) b = -b;
      if (i == 7) b = '0;
      model(a, b, q, r, e);
      // Result must hold the previous value while the new op is busy.
      q = bus.div_result;
      start(a, b);
      repeat (10) tick();
      compared++;
      if (bus.div_result !== q || bus.div_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL rand_hold: got res=%h ready=%b, need res=%h ready=0",
                 bus.div_result, bus.div_ready, q);
      end
      wait_ready(edges);
      model(a, b, q, r, e);
      compared++;
      if (edges !== LATENCY - 10 || bus.div_result !== q || bus.div_exception !== e) begin
        mismatched++;
        $display("FAIL rand_op: got edges=%0d res=%h exc=%b, need edges=%0d res=%h exc=%b (A=%h B=%h)",
                 edges + 10, bus.div_result, bus.div_exception, LATENCY, q, e, a, b);
      end
`ifdef DIVIDER_REMAINDER_EN
      compared++;
      if (bus.div_remainder !== r) begin
        mismatched++;
        $display("FAIL rand_rem: got %h, need %h (A=%h B=%h)", bus.div_remainder, r, a, b);
      end
`endif
      $display("op rand%-6d A=%h B=%h -> Q=%h R=%h exc=%b", i, a, b, q, r, e);
      tick();
    end
  endtask

  task automatic test_restart();
    int edges;
    int early = 0;
    start(32'd100, 32'd7);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.div_ready === 1'b1) early++;
    end
    start(32'd9, 32'd3);
    wait_ready(edges);
    compared++;
    if (early !== 0 || edges !== LATENCY || bus.div_result !== 32'd3) begin
      mismatched++;
      $display("FAIL restart: got early=%0d edges=%0d res=%h, need early=0 edges=%0d res=%h",
               early, edges, bus.div_result, LATENCY, 32'd3);
    end
    tick();
    $display("op restart   9/3 after abort of 100/7 -> Q=%h", bus.div_result);
  endtask

  task automatic test_abort();
    int seen = 0;
    start(32'd100, 32'd7);
    repeat (19) tick();
    stop_DIV = 1'b1;
    tick();
    stop_DIV = 1'b0;
    compared++;
    if (bus.div_ready !== 1'b0 || bus.div_exception !== 1'b0 || bus.div_result !== '0) begin
      mismatched++;
      $display("FAIL abort_clear: got ready=%b exc=%b res=%h, need all 0",
               bus.div_ready, bus.div_exception, bus.div_result);
    end
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      if (bus.div_ready === 1'b1) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL abort_noready: got %0d ready pulses, need 0", seen);
    end
    $display("op abort     stop at cycle 20 -> ready pulses=%0d", seen);
  endtask

  task automatic test_back_to_back();
    int edges;
    start(32'd100, 32'd7);
    repeat (LATENCY - 1) tick();
    compared++;
    if (bus.div_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_early: got ready=%b at edge %0d, need 0", bus.div_ready, LATENCY - 1);
    end
    tick();
    compared++;
    if (bus.div_ready !== 1'b1 || bus.div_result !== 32'd14) begin
      mismatched++;
      $display("FAIL b2b_first: got ready=%b res=%h, need ready=1 res=%h", bus.div_ready, bus.div_result, 32'd14);
    end
    start(32'd50, 32'd5);
    compared++;
    if (bus.div_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_pulse: got ready=%b after DONE, need 0", bus.div_ready);
    end
    wait_ready(edges);
    compared++;
    if (edges !== LATENCY || bus.div_result !== 32'd10 || bus.div_exception !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_second: got edges=%0d res=%h exc=%b, need edges=%0d res=%h exc=0",
               edges, bus.div_result, bus.div_exception, LATENCY, 32'd10);
    end
    tick();
    $display("op b2b       100/7 then 50/5 -> Q=%h", bus.div_result);
  endtask

  initial begin
    stop_DIV = 1'b1;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    test_reset();
    test_signs();
    test_exceptions();
    test_random();
    test_restart();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/divider.md
Name: divider

Overview:
- Multi-cycle signed 32-bit integer divider; the inverse-operation companion to the Booth multiplier in the ALU/datapath.
- Accepts a one-cycle start pulse, latches the operands, and runs a radix-2 restoring divide on operand magnitudes, one quotient bit per cycle, followed by a sign-fix cycle.
- Results are reported with a one-cycle ready pulse plus an exception flag, using the same start/stop/ready handshake as the multiplier.

Parameters:
- DATA_WIDTH, 32, operand/result width. The iteration counter width is ceil(log2(DATA_WIDTH)).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- stop_DIV  input  1  synchronous, active-high reset/abort; clears all state.
- ctrl_DIV  input  1  start pulse, sampled at the rising edge.
- data_operandA  input  DATA_WIDTH  dividend (two's complement), sampled when ctrl_DIV=1.
- data_operandB  input  DATA_WIDTH  divisor (two's complement), sampled when ctrl_DIV=1.
- div_result  output  DATA_WIDTH  quotient, truncated toward zero.
- div_exception  output  1  divide-by-zero or overflow; valid only while div_ready=1.
- div_ready  output  1  one-cycle completion pulse.

Behaviour:
- Reset (stop_DIV=1 at an edge):
  - state=IDLE, counter=0, all internal registers=0.
  - div_result=0, div_exception=0, div_ready=0.
  - Reset mid-operation aborts with no ready pulse.
  - stop_DIV has priority over ctrl_DIV.
- States: IDLE, BUSY, FIX, DONE.
- IDLE / any state + ctrl_DIV=1 at edge k:
  - Latch |A|, |B|, sign_q = A[msb] XOR B[msb], sign_r = A[msb].
  - Latch div0 = (B==0) and ovf = (A==min_neg && B==all-ones).
  - Clear partial remainder R (DATA_WIDTH+1 bits), counter=0; next state BUSY.
  - A start in BUSY/FIX/DONE aborts the current op and restarts. No ready pulse is issued for the aborted op.
- BUSY, one iteration per edge (edges k+1 .. k+DATA_WIDTH):
  - Shift {R,Q} left by 1, bringing in the next dividend bit.
  - T = R - |B|. If T is non-negative, R=T and Q[0]=1; otherwise Q[0]=0.
  - counter++. On the edge where counter==DATA_WIDTH-1, next state is FIX.
- FIX (edge k+DATA_WIDTH+1):
  - div_result = sign_q ? -Q : Q.
  - If div0: div_result=0, exception=1.
  - If ovf: div_result=min_neg (0x80000000), exception=1.
  - div_ready register set to 1; next state DONE.
- DONE:
  - div_ready=1 for exactly this one cycle. Next edge: div_ready=0, state IDLE, unless ctrl_DIV=1, in which case go to BUSY.
- Latency: div_ready visible in the cycle after edge k+DATA_WIDTH+1, i.e. 33 edges after the start edge for DATA_WIDTH=32.
- div_result is held from FIX until the next FIX or reset; it does not change during BUSY.
- div_exception is a registered flag ANDed with div_ready, so it reads 0 whenever div_ready=0.
- Divide-by-zero takes the full latency; there is no early exit.
- Operands may change after the start edge without effect.
- ctrl_DIV held high for several cycles restarts every cycle; only the final start completes.

Optional Feature:
- Macro DIVIDER_REMAINDER_EN.
- Defined:
  - Adds output div_remainder [DATA_WIDTH-1:0] = sign_r ? -R : R, registered at FIX alongside div_result.
  - Remainder is 0 on div0 and on ovf; reset value 0; held like div_result.
- Undefined:
  - Port absent; R is internal only.
  - All other behaviour and timing are identical.

Test Plan:
- Basic: A=100, B=7, ctrl_DIV one cycle.
  - div_ready high for exactly one cycle, 33 edges after the start edge.
  - div_result=14, div_exception=0; div_remainder=2 if enabled.
- Signs: A=-100 (0xFFFFFF9C), B=7 → div_result=0xFFFFFFF2 (-14), remainder -2 (0xFFFFFFFE).
  - A=100, B=-7 → -14, remainder 2.
  - A=-100, B=-7 → 14, remainder -2.
- Divide-by-zero: A=5, B=0 → div_result=0, div_exception=1 during the ready cycle, 0 on the next cycle.
- Overflow: A=0x80000000, B=0xFFFFFFFF → div_result=0x80000000, div_exception=1.
  - Then A=0x80000000, B=1 → 0x80000000, exception=0.
- Restart/abort:
  - Start 100/7, re-pulse ctrl_DIV at cycle 10 with 9/3 → single ready pulse 33 edges after the second start, div_result=3.
  - Assert stop_DIV at cycle 20 of an op → no ready pulse; all outputs 0 the cycle after.
- Back-to-back: pulse ctrl_DIV (50/5) in the DONE cycle of the previous op → previous ready still seen for that cycle; next ready 33 edges later with div_result=10.
